reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
Parametrised register scoreboard replacing the fixed four-stage dependency comparator in the in-order pipeline. It keeps an in-order FIFO of in-flight instructions and a per-register pending-writer counter. From these it raises a decode stall on RAW hazards or a full pipeline, and it supports partial flush of the youngest entries on a taken jump. It sits beside the decode stage. Issue happens at the ID/RR boundary; retire happens at WB.

Parameters:
NUM_REGS, 8, number of architectural registers.
IDX_W, 3, register index width (2^IDX_W >= NUM_REGS).
DEPTH, 4, maximum in-flight instructions (RR..WB stages). Must be >= 1.
CNT_W, 3, per-register pending-writer counter width. Must satisfy 2^CNT_W-1 >= DEPTH.
RETIRE_BYPASS, 1, if 1, a same-cycle retire of the last writer clears the hazard for the issuing instruction.
ZERO_REG, 0, if 1, register 0 is never marked busy and never causes a stall.
(localparam OCC_W = clog2(DEPTH+1))

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
iss_valid  in  1  decode has an instruction to issue
iss_wen  in  1  issuing instruction writes a register
iss_dst  in  IDX_W  destination index
iss_rd1  in  1  source 1 is read
iss_src1  in  IDX_W  source 1 index
iss_rd2  in  1  source 2 is read
iss_src2  in  IDX_W  source 2 index
iss_ready  out  1  combinational; issue accepted this cycle when iss_valid && iss_ready
stall  out  1  combinational; iss_valid && !iss_ready
ret_valid  in  1  oldest in-flight instruction leaves WB this cycle
ret_wen  out  1  head entry write-enable (registered state)
ret_dst  out  IDX_W  head entry destination (registered state)
flush  in  1  discard youngest flush_n entries
flush_n  in  OCC_W  number of youngest entries to discard
busy  out  NUM_REGS  bit r = pending-writer count of r is non-zero
count  out  OCC_W  occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0
err  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst low, async): FIFO pointers = 0, count = 0, all counters = 0, busy = 0, err = 0, empty = 1, full = 0. ret_wen = 0 and ret_dst = 0 when empty.
- Hazard: hz(s) = rd && cnt[s] != 0. With RETIRE_BYPASS=1, hz(s) is also cleared when ret_valid && ret_wen && ret_dst == s && cnt[s] == 1. With ZERO_REG=1, hz(0) = 0.
- iss_ready = !flush && !hz(src1) && !hz(src2) && (!full || (ret_valid && !empty)).
- Issue (iss_valid && iss_ready): push {iss_wen, iss_dst} at the tail. If iss_wen (and not reg 0 with ZERO_REG=1), increment cnt[iss_dst].
- Retire (ret_valid && !empty): pop the head. If the head wen is set, decrement cnt[head dst].
- Issue and retire in the same cycle: both take effect. count is unchanged. If both target the same register, its counter is unchanged.
- Flush: n = min(flush_n, count - (ret_valid && !empty ? 1 : 0)). Remove the n youngest entries: tail moves back by n, and each removed entry with wen set decrements its counter. Retire is processed in the same cycle. Issue is blocked (iss_ready = 0). A flush_n greater than the available count sets err and is clamped.
- Multiple decrements of one register in a single cycle are summed. Counters never underflow.
- err is sticky until reset. It is set by: ret_valid while empty (ignored), flush_n over-range, or a counter increment at saturation (increment dropped).
- All state is registered. busy, count, full, empty and ret_* reflect post-edge state with 1-cycle latency from issue/retire/flush.
- Pointers wrap modulo DEPTH; non-power-of-2 DEPTH is supported.
- Reset asserted mid-operation discards all entries immediately.

Test Plan:
- Reset, then issue wen=1 dst=3 -> next cycle busy=8'h08, count=1. An issue reading src1=3 gives stall=1 until that entry retires.
- RETIRE_BYPASS=1: busy[3] with one writer; ret_valid at the head of dst=3 in the same cycle as an issue reading r3 -> iss_ready=1. With RETIRE_BYPASS=0 -> stall=1.
- Fill to DEPTH=4 with independent writes (dst 0..3) -> full=1 and a fifth issue stalls. The same fifth issue alongside ret_valid -> accepted, and count stays 4.
- Issue dst 1,2,2,5, then flush flush_n=2 -> count=2, busy=8'h06, cnt[2]=1, and iss_ready=0 during the flush cycle.
- Two writers to r4 in flight; retire the first -> busy[4] stays 1; retire the second -> busy[4]=0.
- ret_valid while empty -> err=1, and it stays 1 until rst is asserted low. flush_n=3 with count=1 -> count=0, err=1.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register scoreboard: in-order FIFO of in-flight writers plus per-register pending counts.
// Issue ready/stall are combinational. All state updates one cycle after issue/retire/flush.
module reg_scoreboard #(
   parameter int NUM_REGS      = 8,
   parameter int IDX_W         = 3,
   parameter int DEPTH         = 4,
   parameter int CNT_W         = 3,
   parameter bit RETIRE_BYPASS = 1'b1,
   parameter bit ZERO_REG      = 1'b0,
   localparam int OCC_W        = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                iss_valid,
   input  logic                iss_wen,
   input  logic [IDX_W-1:0]    iss_dst,
   input  logic                iss_rd1,
   input  logic [IDX_W-1:0]    iss_src1,
   input  logic                iss_rd2,
   input  logic [IDX_W-1:0]    iss_src2,
   output logic                iss_ready,
   output logic                stall,
   input  logic                ret_valid,
   output logic                ret_wen,
   output logic [IDX_W-1:0]    ret_dst,
   input  logic                flush,
   input  logic [OCC_W-1:0]    flush_n,
   output logic [NUM_REGS-1:0] busy,
   output logic [OCC_W-1:0]    count,
   output logic                full,
   output logic                empty,
   output logic                err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   if (DEPTH < 1) begin : g_bad_depth
      $error("reg_scoreboard: DEPTH must be at least 1");
   end
   if ((2 ** CNT_W) - 1 < DEPTH) begin : g_bad_cnt_w
      $error("reg_scoreboard: CNT_W too narrow for DEPTH");
   end
   if ((2 ** IDX_W) < NUM_REGS) begin : g_bad_idx_w
      $error("reg_scoreboard: IDX_W too narrow for NUM_REGS");
   end

   logic                 ent_wen_q [DEPTH];
   logic [IDX_W-1:0]     ent_dst_q [DEPTH];
   logic [CNT_W-1:0]     cnt_q     [NUM_REGS];
   logic [CNT_W-1:0]     cnt_d     [NUM_REGS];
   logic [CNT_W:0]       dec       [NUM_REGS];
   logic [PTR_W-1:0]     head_q, head_d;
   logic [PTR_W-1:0]     tail_q, tail_d;
   logic [OCC_W-1:0]     count_q, count_d;
   logic                 err_q, err_d;

   logic                 head_wen;
   logic [IDX_W-1:0]     head_dst;
   logic                 ret_fire;
   logic                 iss_fire;
   logic                 hz1, hz2;
   logic [CNT_W-1:0]     c1, c2;
   logic [OCC_W-1:0]     avail;
   logic [OCC_W-1:0]     flush_cnt;
   logic                 flush_over;
   logic                 sat_err;
   logic                 inc;
   logic [CNT_W:0]       val;
   logic [PTR_W-1:0]     rm_idx;
   int                   rm_pos;
   int                   tail_back;

   assign head_wen = ent_wen_q[head_q];
   assign head_dst = ent_dst_q[head_q];
   assign empty    = (count_q == '0);
   assign full     = (count_q == OCC_W'(DEPTH));
   assign count    = count_q;
   assign err      = err_q;
   assign ret_wen  = !empty && head_wen;
   assign ret_dst  = empty ? '0 : head_dst;
   assign ret_fire = ret_valid && !empty;

   // Source hazards, optionally relieved when the sole pending writer retires now.
   always_comb begin
      c1 = '0;
      c2 = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (IDX_W'(r) == iss_src1) c1 = cnt_q[r];
         if (IDX_W'(r) == iss_src2) c2 = cnt_q[r];
      end
      hz1 = iss_rd1 && (c1 != '0);
      hz2 = iss_rd2 && (c2 != '0);
      if (RETIRE_BYPASS) begin
         if (ret_fire && head_wen && (head_dst == iss_src1) && (c1 == CNT_W'(1))) hz1 = 1'b0;
         if (ret_fire && head_wen && (head_dst == iss_src2) && (c2 == CNT_W'(1))) hz2 = 1'b0;
      end
      if (ZERO_REG) begin
         if (iss_src1 == '0) hz1 = 1'b0;
         if (iss_src2 == '0) hz2 = 1'b0;
      end
   end

   assign iss_ready = !flush && !hz1 && !hz2 && (!full || ret_fire);
   assign iss_fire  = iss_valid && iss_ready;
   assign stall     = iss_valid && !iss_ready;

   // Flush may only remove entries that survive this cycle's retire.
   assign avail      = count_q - OCC_W'(ret_fire);
   assign flush_over = flush && (flush_n > avail);
   assign flush_cnt  = !flush ? '0 : (flush_over ? avail : flush_n);

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) dec[r] = '0;
      rm_pos = 0;
      rm_idx = '0;
      if (ret_fire && head_wen) begin
         for (int r = 0; r < NUM_REGS; r++)
            if (IDX_W'(r) == head_dst) dec[r] = dec[r] + (CNT_W+1)'(1);
      end
      for (int k = 0; k < DEPTH; k++) begin
         if (k < int'(flush_cnt)) begin
            rm_pos = int'(tail_q) - 1 - k;
            if (rm_pos < 0) rm_pos = rm_pos + DEPTH;
            rm_idx = PTR_W'(rm_pos);
            for (int r = 0; r < NUM_REGS; r++)
               if (ent_wen_q[rm_idx] && (IDX_W'(r) == ent_dst_q[rm_idx]))
                  dec[r] = dec[r] + (CNT_W+1)'(1);
         end
      end
   end

   // Counter update: increment dropped at saturation, decrement floored at zero.
   always_comb begin
      sat_err = 1'b0;
      inc     = 1'b0;
      val     = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         inc = iss_fire && iss_wen && (IDX_W'(r) == iss_dst) && !(ZERO_REG && r == 0);
         val = {1'b0, cnt_q[r]};
         if (inc) begin
            if ((cnt_q[r] == CNT_MAX) && (dec[r] == '0)) sat_err = 1'b1;
            else val = val + (CNT_W+1)'(1);
         end
         cnt_d[r] = (val > dec[r]) ? CNT_W'(val - dec[r]) : '0;
      end
   end

   always_comb begin
      head_d = head_q;
      if (ret_fire) head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + 1'b1;
      tail_back = int'(tail_q) - int'(flush_cnt);
      if (tail_back < 0) tail_back = tail_back + DEPTH;
      tail_d = PTR_W'(tail_back);
      if (iss_fire) tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
      count_d = count_q - OCC_W'(ret_fire) - flush_cnt + OCC_W'(iss_fire);
      err_d   = err_q || (ret_valid && empty) || flush_over || sat_err;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         err_q   <= err_d;
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            ent_wen_q[k] <= 1'b0;
            ent_dst_q[k] <= '0;
         end
      end else if (iss_fire) begin
         ent_wen_q[tail_q] <= iss_wen;
         ent_dst_q[tail_q] <= iss_dst;
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) busy[r] = (cnt_q[r] != '0);
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: queue-based reference model checked every cycle, plus directed literals.
module tb_reg_scoreboard;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       iss_valid, iss_wen, iss_rd1, iss_rd2;
   logic [2:0] iss_dst, iss_src1, iss_src2;
   logic       ret_valid, flush;
   logic [2:0] flush_n;

   logic       iss_ready, stall, ret_wen, full, empty, err;
   logic [2:0] ret_dst, count;
   logic [7:0] busy;

   logic       nb_iss_ready, nb_stall, nb_ret_wen, nb_full, nb_empty, nb_err;
   logic [2:0] nb_ret_dst, nb_count;
   logic [7:0] nb_busy;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic       wen;
      logic [2:0] dst;
   } ent_t;

   ent_t mq[$];
   bit   merr;

   always #5 clk = ~clk;

   reg_scoreboard u_dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_dst(iss_dst),
      .iss_rd1(iss_rd1), .iss_src1(iss_src1), .iss_rd2(iss_rd2), .iss_src2(iss_src2),
      .iss_ready(iss_ready), .stall(stall),
      .ret_valid(ret_valid), .ret_wen(ret_wen), .ret_dst(ret_dst),
      .flush(flush), .flush_n(flush_n),
      .busy(busy), .count(count), .full(full), .empty(empty), .err(err)
   );

   reg_scoreboard #(.RETIRE_BYPASS(1'b0)) u_nb (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_dst(iss_dst),
      .iss_rd1(iss_rd1), .iss_src1(iss_src1), .iss_rd2(iss_rd2), .iss_src2(iss_src2),
      .iss_ready(nb_iss_ready), .stall(nb_stall),
      .ret_valid(ret_valid), .ret_wen(nb_ret_wen), .ret_dst(nb_ret_dst),
      .flush(flush), .flush_n(flush_n),
      .busy(nb_busy), .count(nb_count), .full(nb_full), .empty(nb_empty), .err(nb_err)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // A source is hazardous while any queued writer targets it, unless the only one retires now.
   function automatic bit hz(input bit rd, input logic [2:0] s, input bit rf);
      int p = 0;
      foreach (mq[i]) if (mq[i].wen && mq[i].dst == s) p++;
      if (!rd || p == 0) return 1'b0;
      if (rf && mq[0].wen && mq[0].dst == s && p == 1) return 1'b0;
      return 1'b1;
   endfunction

   always @(negedge clk) begin : compare
      logic [7:0] eb;
      bit         rf, er;
      int         n;
      if (!rst) begin
         mq.delete();
         merr = 1'b0;
      end
      eb = '0;
      foreach (mq[i]) if (mq[i].wen) eb[mq[i].dst] = 1'b1;
      rf = ret_valid && (mq.size() != 0);
      er = !flush && !hz(iss_rd1, iss_src1, rf) && !hz(iss_rd2, iss_src2, rf)
           && (mq.size() < DEPTH || rf);
      chk("busy",      int'(busy),      int'(eb));
      chk("count",     int'(count),     mq.size());
      chk("full",      int'(full),      int'(mq.size() == DEPTH));
      chk("empty",     int'(empty),     int'(mq.size() == 0));
      chk("ret_wen",   int'(ret_wen),   (mq.size() == 0) ? 0 : int'(mq[0].wen));
      chk("ret_dst",   int'(ret_dst),   (mq.size() == 0) ? 0 : int'(mq[0].dst));
      chk("err",       int'(err),       int'(merr));
      chk("iss_ready", int'(iss_ready), int'(er));
      chk("stall",     int'(stall),     int'(iss_valid && !er));
      if (rst) begin
         if (ret_valid && mq.size() == 0) merr = 1'b1;
         if (rf) void'(mq.pop_front());
         if (flush) begin
            n = int'(flush_n);
            if (n > mq.size()) begin
               merr = 1'b1;
               n = mq.size();
            end
            repeat (n) void'(mq.pop_back());
         end
         if (iss_valid && er) mq.push_back('{wen: iss_wen, dst: iss_dst});
      end
   end

   task automatic idle();
      iss_valid = 0; iss_wen = 0; iss_dst = 0;
      iss_rd1 = 0; iss_src1 = 0; iss_rd2 = 0; iss_src2 = 0;
      ret_valid = 0; flush = 0; flush_n = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic issue(input logic wen, input logic [2:0] dst);
      iss_valid = 1; iss_wen = wen; iss_dst = dst;
      cyc();
      idle();
   endtask

   initial begin
      idle();
      rst = 0;
      repeat (3) cyc();
      rst = 1;
      mid();
      chk("reset_empty", int'(empty), 1);
      chk("reset_busy", int'(busy), 0);
      cyc();

      // RAW stall on r3, then same-cycle retire bypass vs. no-bypass instance
      issue(1, 3);
      mid();
      chk("a_busy", int'(busy), 'h08);
      chk("a_count", int'(count), 1);
      cyc();
      iss_valid = 1; iss_rd1 = 1; iss_src1 = 3;
      mid();
      chk("a_stall", int'(stall), 1);
      chk("a_nb_stall", int'(nb_stall), 1);
      cyc();
      ret_valid = 1;
      mid();
      chk("a_bypass_ready", int'(iss_ready), 1);
      chk("a_nobypass_stall", int'(nb_stall), 1);
      cyc();
      idle();
      ret_valid = 1;
      cyc();
      idle();

      // Fill to DEPTH, fifth issue stalls, then accepted alongside a retire
      for (int d = 0; d < 4; d++) issue(1, 3'(d));
      mid();
      chk("b_full", int'(full), 1);
      chk("b_count", int'(count), 4);
      cyc();
      iss_valid = 1; iss_wen = 1; iss_dst = 5;
      mid();
      chk("b_fifth_stall", int'(stall), 1);
      cyc();
      ret_valid = 1;
      mid();
      chk("b_fifth_ready", int'(iss_ready), 1);
      cyc();
      idle();
      mid();
      chk("b_count_kept", int'(count), 4);
      chk("b_busy", int'(busy), 'h2e);
      cyc();
      ret_valid = 1;
      repeat (4) cyc();
      idle();
      mid();
      chk("b_drained", int'(empty), 1);
      cyc();

      // Partial flush of the two youngest entries
      issue(1, 1); issue(1, 2); issue(1, 2); issue(1, 5);
      flush = 1; flush_n = 2; iss_valid = 1;
      mid();
      chk("c_flush_ready", int'(iss_ready), 0);
      cyc();
      idle();
      mid();
      chk("c_count", int'(count), 2);
      chk("c_busy", int'(busy), 'h06);
      cyc();
      ret_valid = 1; cyc(); idle();
      mid();
      chk("c_busy_r2", int'(busy), 'h04);
      cyc();
      ret_valid = 1; cyc(); idle();
      mid();
      chk("c_busy_clear", int'(busy), 0);
      cyc();

      // Two writers to r4
      issue(1, 4); issue(1, 4);
      ret_valid = 1; cyc(); idle();
      mid();
      chk("d_busy4_first", int'(busy[4]), 1);
      cyc();
      ret_valid = 1; cyc(); idle();
      mid();
      chk("d_busy4_second", int'(busy[4]), 0);
      chk("d_err_clean", int'(err), 0);
      cyc();

      // Over-range flush clamps and flags; empty retire flags; err sticky until reset
      issue(1, 6);
      flush = 1; flush_n = 3; cyc(); idle();
      mid();
      chk("e_flush_count", int'(count), 0);
      chk("e_flush_err", int'(err), 1);
      cyc();
      rst = 0; cyc(); rst = 1;
      mid();
      chk("e_err_cleared", int'(err), 0);
      cyc();
      ret_valid = 1; cyc(); idle();
      repeat (5) cyc();
      mid();
      chk("e_err_sticky", int'(err), 1);
      cyc();
      rst = 0;
      mid();
      chk("e_err_reset", int'(err), 0);
      cyc();
      rst = 1;

      // Randomized traffic, with occasional mid-operation reset
      for (int c = 0; c < 4000; c++) begin
         iss_valid = ($urandom_range(0, 9) < 7);
         iss_wen   = ($urandom_range(0, 3) != 0);
         iss_dst   = 3'($urandom_range(0, 7));
         iss_rd1   = $urandom_range(0, 1) == 1;
         iss_src1  = 3'($urandom_range(0, 7));
         iss_rd2   = $urandom_range(0, 1) == 1;
         iss_src2  = 3'($urandom_range(0, 7));
         ret_valid = ($urandom_range(0, 99) < 45);
         flush     = ($urandom_range(0, 99) < 8);
         flush_n   = 3'($urandom_range(0, 5));
         rst       = ($urandom_range(0, 399) != 0);
         cyc();
      end
      rst = 1;
      idle();
      repeat (2) cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
